// File: rtl/fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fx_pkg
//  Purpose  : Shared constants and helpers for fixed-point format converters.
//  Revision : 1.0  initial release
// ============================================================================
package fx_pkg;

  // Rounding rules applied when fractional LSBs are removed
  localparam int FX_RND_FLOOR  = 0;
  localparam int FX_RND_HALFUP = 1;
  localparam int FX_RND_CONV   = 2;

  // Handling of results that do not fit the output word
  localparam int FX_OVF_WRAP = 0;
  localparam int FX_OVF_SAT  = 1;

  // Width of a value after one guard bit is added and SHIFT LSBs are dropped
  function automatic int fx_rnd_width(input int in_w, input int shift);
    return in_w + 1 - shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx_round_sat.sv
`default_nettype none
// ============================================================================
//  Module   : fx_round_sat
//  Purpose  : Combinational rounding (floor / half-up / half-to-even) followed
//             by saturate-or-wrap fitting to OUT_W bits, with overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module fx_round_sat
  import fx_pkg::*;
#(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 14,
  parameter int SHIFT      = 2,
  parameter int ROUND_MODE = FX_RND_HALFUP,
  parameter int SAT_MODE   = FX_OVF_SAT
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam int RW = fx_rnd_width(IN_W, SHIFT);

  localparam logic [IN_W:0]    ONE     = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0]    HALF    = ONE << (SHIFT - 1);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W:0]    ext;
  logic [IN_W:0]    bias;
  logic [IN_W:0]    sum;
  logic [RW-1:0]    rnd;
  logic [OUT_W-1:0] fit;
  logic             unused_frac;

  // One guard bit keeps the bias addition from overflowing
  assign ext = {din[IN_W-1], din};

  // Rounding bias: half-to-even adds half minus one, plus the kept LSB
  always_comb begin
    bias = '0;
    if (ROUND_MODE == FX_RND_HALFUP) begin
      bias = HALF;
    end else if (ROUND_MODE == FX_RND_CONV) begin
      bias = HALF - ONE + {{IN_W{1'b0}}, ext[SHIFT]};
    end
  end

  assign sum = ext + bias;
  // Slicing off the LSBs of a sign-extended sum is the arithmetic shift
  assign rnd = sum[IN_W:SHIFT];
  assign unused_frac = ^sum[SHIFT-1:0];

  generate
    if (RW > OUT_W) begin : g_narrow
      // Fits only if every bit from the output sign bit upward agrees
      assign ovf = ~((&rnd[RW-1:OUT_W-1]) | ~(|rnd[RW-1:OUT_W-1]));
      assign fit = rnd[OUT_W-1:0];
    end else begin : g_wide
      assign ovf = 1'b0;
      assign fit = OUT_W'($signed(rnd));
    end
  endgenerate

  // Replace out-of-range results with the nearest representable extreme
  always_comb begin
    dout = fit;
    if ((SAT_MODE == FX_OVF_SAT) && ovf) begin
      dout = rnd[RW-1] ? MIN_NEG : MAX_POS;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fx_requant_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fx_requant_pipe
//  Purpose  : Three-stage valid/ready requantizer: drops SHIFT fraction bits
//             with selectable rounding, fits to OUT_W, tracks overflows.
//  Revision : 1.0  initial release
// ============================================================================
module fx_requant_pipe
  import fx_pkg::*;
#(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 14,
  parameter int SHIFT      = 2,
  parameter int ROUND_MODE = FX_RND_HALFUP,
  parameter int SAT_MODE   = FX_OVF_SAT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  input  logic             i_ready,
  input  logic             i_clr_stat,
  output logic             o_ovf_sticky,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  logic             en;
  logic             s1_valid;
  logic [IN_W-1:0]  s1_data;
  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;
  logic             s2_ovf;
  logic [OUT_W-1:0] rs_data;
  logic             rs_ovf;
  logic             stat_hit;

  // The whole pipe moves in lockstep; only a held output blocks it
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Rounding and fitting sit in front of the S2 register
  fx_round_sat #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .SHIFT      (SHIFT),
    .ROUND_MODE (ROUND_MODE),
    .SAT_MODE   (SAT_MODE)
  ) u_round_sat (
    .din  (s1_data),
    .dout (rs_data),
    .ovf  (rs_ovf)
  );

  // Advance S1 -> S2 -> S3 together; bubbles travel like samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_data  <= i_data;
      s2_valid <= s1_valid;
      s2_data  <= rs_data;
      s2_ovf   <= rs_ovf;
      o_valid  <= s2_valid;
      o_data   <= s2_data;
    end
  end

  // A valid overflowing sample moving into S3 counts once
  assign stat_hit = en & s2_valid & s2_ovf;

  // Overflow statistics; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ovf_sticky <= 1'b0;
      o_ovf_cnt    <= '0;
    end else if (i_clr_stat) begin
      o_ovf_sticky <= 1'b0;
      o_ovf_cnt    <= '0;
    end else if (stat_hit) begin
      o_ovf_sticky <= 1'b1;
      if (~&o_ovf_cnt) begin
        o_ovf_cnt <= o_ovf_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fx_requant_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fx_requant_pipe
//  Purpose  : Self-checking bench for fx_requant_pipe; four configurations
//             share one stimulus stream and one scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fx_requant_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [11:0] i_data = '0;
  logic        i_ready = 1'b1;
  logic        i_clr_stat = 1'b0;

  // Default config: half-up, 14-bit, saturate
  logic        d_ready, d_valid, d_sticky;
  logic [13:0] d_data;
  logic [15:0] d_cnt;
  // Convergent rounding
  logic        c_ready, c_valid, c_sticky;
  logic [13:0] c_data;
  logic [15:0] c_cnt;
  // 8-bit saturating
  logic        s_ready, s_valid, s_sticky;
  logic [7:0]  s_data;
  logic [15:0] s_cnt;
  // 8-bit wrapping
  logic        w_ready, w_valid, w_sticky;
  logic [7:0]  w_data;
  logic [15:0] w_cnt;

  int checks   = 0;
  int failures = 0;
  logic [11:0] sb[$];
  logic        held = 1'b0;
  logic [13:0] held_data = '0;

  always #5 clk = ~clk;

  fx_requant_pipe u_def (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(d_ready),
    .o_valid(d_valid), .o_data(d_data), .i_ready(i_ready), .i_clr_stat(i_clr_stat),
    .o_ovf_sticky(d_sticky), .o_ovf_cnt(d_cnt));

  fx_requant_pipe #(.ROUND_MODE(2)) u_conv (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(c_ready),
    .o_valid(c_valid), .o_data(c_data), .i_ready(i_ready), .i_clr_stat(i_clr_stat),
    .o_ovf_sticky(c_sticky), .o_ovf_cnt(c_cnt));

  fx_requant_pipe #(.OUT_W(8), .SAT_MODE(1)) u_sat8 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(s_ready),
    .o_valid(s_valid), .o_data(s_data), .i_ready(i_ready), .i_clr_stat(i_clr_stat),
    .o_ovf_sticky(s_sticky), .o_ovf_cnt(s_cnt));

  fx_requant_pipe #(.OUT_W(8), .SAT_MODE(0)) u_wrap8 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(w_ready),
    .o_valid(w_valid), .o_data(w_data), .i_ready(i_ready), .i_clr_stat(i_clr_stat),
    .o_ovf_sticky(w_sticky), .o_ovf_cnt(w_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value/4 with the chosen rounding, then clamp or wrap to ow bits
  function automatic logic [31:0] model(input logic [11:0] d, input int rm, input int ow, input int sat);
    int v, q, r, hi, lo;
    v = int'($signed(d));
    q = v >>> 2;
    r = v - q * 4;
    if (rm == 1 && r >= 2) q = q + 1;
    if (rm == 2 && (r > 2 || (r == 2 && (q & 1) != 0))) q = q + 1;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (sat != 0) begin
      if (q > hi) q = hi;
      if (q < lo) q = lo;
    end
    return 32'(q & ((1 << ow) - 1));
  endfunction

  // Mid-cycle monitor: score outputs, verify stalls, record accepted inputs
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) check("stall_hold", 32'(d_data), 32'(held_data));
      if (d_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          logic [11:0] d;
          d = sb.pop_front();
          check("out_def",   32'(d_data), model(d, 1, 14, 1));
          check("out_conv",  32'(c_data), model(d, 2, 14, 1));
          check("out_sat8",  32'(s_data), model(d, 1, 8, 1));
          check("out_wrap8", 32'(w_data), model(d, 1, 8, 0));
        end
      end
      if (d_valid && !i_ready) begin
        check("stall_ready", 32'(d_ready), 32'd0);
        held      = 1'b1;
        held_data = d_data;
      end else begin
        held = 1'b0;
      end
      if (i_valid && d_ready) sb.push_back(i_data);
    end
  end

  task automatic send(input logic [11:0] d);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = d_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  32'(d_valid), 32'd0);
    check("rst_data",   32'(d_data), 32'd0);
    check("rst_sticky", 32'(s_sticky), 32'd0);
    check("rst_cnt",    32'(s_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Rounding patterns in every configuration
    send(12'h007);
    send(12'hFFA);
    send(12'h00A);
    send(12'h00E);
    drain();
    check("def_sticky", 32'(d_sticky), 32'd0);
    check("sat_no_ovf", 32'(s_cnt), 32'd0);

    // Positive and negative overflow at 8 bits
    send(12'h7FF);
    drain();
    check("ovf1_sticky", 32'(s_sticky), 32'd1);
    check("ovf1_cnt",    32'(s_cnt), 32'd1);
    check("ovf1_wcnt",   32'(w_cnt), 32'd1);
    send(12'h800);
    drain();
    check("ovf2_cnt", 32'(s_cnt), 32'd2);
    check("def_cnt",  32'(d_cnt), 32'd0);

    // Five back-to-back samples with a three-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 5; k++) send(12'(16 + 19 * k));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three samples in flight
    send(12'h7FF);
    send(12'h7FF);
    send(12'h7FF);
    check("pre_rst_valid", 32'(s_valid), 32'd1);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_valid",  32'(s_valid), 32'd0);
    check("arst_cnt",    32'(s_cnt), 32'd0);
    check("arst_sticky", 32'(s_sticky), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: transfer edge counts as cycle 1, o_valid after the third
    send(12'h005);
    n = 1;
    while (!d_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd3);
    drain();

    // Clear coinciding with an overflowing S2->S3 transfer
    send(12'h7FF);
    @(posedge clk);
    #1;
    i_clr_stat = 1'b1;
    @(posedge clk);
    #1;
    i_clr_stat = 1'b0;
    check("clr_cnt",    32'(s_cnt), 32'd0);
    check("clr_sticky", 32'(s_sticky), 32'd0);
    check("clr_wcnt",   32'(w_cnt), 32'd0);
    drain();
    send(12'h800);
    drain();
    check("post_clr_cnt",    32'(s_cnt), 32'd1);
    check("post_clr_sticky", 32'(s_sticky), 32'd1);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
